// File: rtl/dmem_scan_arbiter_pkg.sv
// Shared types and constants for the data-memory scan arbiter: window geometry,
// index type and scanner state encoding.
package dmem_scan_arbiter_pkg;

   localparam int DISP_BASE_ADDR = 4096;
   localparam int DISP_WORD_NUM  = 8;
   localparam int DISP_IDX_W     = $clog2(DISP_WORD_NUM);

   typedef logic [DISP_IDX_W-1:0] disp_index_t;

   typedef logic [1:0] scan_state_t;
   localparam scan_state_t SCAN_IDLE    = 2'd0;
   localparam scan_state_t SCAN_ISSUE   = 2'd1;
   localparam scan_state_t SCAN_CAPTURE = 2'd2;
   localparam scan_state_t SCAN_DONE    = 2'd3;

   // Counter width helper that never collapses to zero bits.
   function automatic int cnt_width(input int states);
      return (states > 1) ? $clog2(states) : 1;
   endfunction

endpackage

// File: rtl/dmem_scan_arbiter_shadow.sv
// Shadow copy of the display window: one register per word, written by the
// scanner capture and by CPU write snoops (snoop has priority), read combinationally.
module dmem_scan_arbiter_shadow
   import dmem_scan_arbiter_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int WORDS  = DISP_WORD_NUM,
   parameter int IDX_W  = $clog2(DISP_WORD_NUM)
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              cap_en,
   input  logic [IDX_W-1:0]  cap_idx,
   input  logic [DATA_W-1:0] cap_data,
   input  logic              snoop_en,
   input  logic [IDX_W-1:0]  snoop_idx,
   input  logic [DATA_W-1:0] snoop_data,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [WORDS-1:0][DATA_W-1:0] file;

   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_entry
         logic [DATA_W-1:0] entry_reg;

         // A snoop reflects a write that happened after the scanner's read, so it wins.
         always_ff @(posedge clk) begin
            if (srst) begin
               entry_reg <= '0;
            end else if (snoop_en && (snoop_idx == IDX_W'(gi))) begin
               entry_reg <= snoop_data;
            end else if (cap_en && (cap_idx == IDX_W'(gi))) begin
               entry_reg <= cap_data;
            end
         end

         assign file[gi] = entry_reg;
      end
   endgenerate

   assign rd_data = file[rd_idx];

endmodule

// File: rtl/dmem_scan_arbiter.sv
// Shares the dmem port between the CPU and a background display scanner.
// Optional starvation stall: define DMEM_SCAN_STARVE_STALL_EN.
module dmem_scan_arbiter
   import dmem_scan_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 32,
   parameter int DISP_BASE      = DISP_BASE_ADDR,
   parameter int DISP_WORDS     = DISP_WORD_NUM,
   parameter int REFRESH_CYCLES = 1024,
   parameter int MAX_WAIT       = 15
) (
   input  logic                          clkX4,
   input  logic                          rst,
   input  logic                          cpu_req,
   input  logic                          cpu_we,
   input  logic [ADDR_W-1:0]             cpu_addr,
   input  logic [DATA_W-1:0]             cpu_wdata,
   output logic [DATA_W-1:0]             cpu_rdata,
   output logic                          cpu_stall,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic                          mem_we,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata,
   input  logic [$clog2(DISP_WORDS)-1:0] disp_sel,
   output logic [DATA_W-1:0]             disp_word,
   output logic                          disp_valid,
   output logic                          frame_done
);

   localparam int IDX_W = $clog2(DISP_WORDS);
   localparam int CNT_W = cnt_width(REFRESH_CYCLES);
   localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(DISP_BASE);
   localparam logic [ADDR_W-1:0] WORDS_A  = ADDR_W'(DISP_WORDS);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DISP_WORDS - 1);

   generate
      if ((longint'(DISP_BASE) + longint'(DISP_WORDS)) > (longint'(1) << ADDR_W)) begin : g_bad_window
         $error("display window exceeds the dmem address space");
      end
      if ((DISP_WORDS < 2) || (DISP_WORDS > 16) || ((DISP_WORDS & (DISP_WORDS - 1)) != 0)) begin : g_bad_words
         $error("DISP_WORDS must be a power of two between 2 and 16");
      end
      if ((REFRESH_CYCLES < 2) || (MAX_WAIT < 1)) begin : g_bad_timing
         $error("REFRESH_CYCLES must be at least 2 and MAX_WAIT at least 1");
      end
   endgenerate

   scan_state_t       state_reg, state_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic [CNT_W-1:0]  refresh_reg;
   logic              disp_valid_reg;
   logic              tick;
   logic              stall;
   logic              cpu_access;
   logic              scan_grant;
   logic [ADDR_W-1:0] win_offset;
   logic              in_window;
   logic              snoop_en;

   assign tick = (refresh_reg == CNT_LAST);

   always_ff @(posedge clkX4) begin
      if (rst) begin
         refresh_reg <= '0;
      end else if (tick) begin
         refresh_reg <= '0;
      end else begin
         refresh_reg <= refresh_reg + CNT_W'(1);
      end
   end

`ifdef DMEM_SCAN_STARVE_STALL_EN
   localparam int WAIT_W = cnt_width(MAX_WAIT + 1);
   logic [WAIT_W-1:0] wait_reg;

   // At the limit the CPU access is suppressed and the scanner takes the slot.
   assign stall = (state_reg == SCAN_ISSUE) && cpu_req && (wait_reg == WAIT_W'(MAX_WAIT));

   always_ff @(posedge clkX4) begin
      if (rst) begin
         wait_reg <= '0;
      end else if ((state_reg != SCAN_ISSUE) || scan_grant) begin
         wait_reg <= '0;
      end else begin
         wait_reg <= wait_reg + WAIT_W'(1);
      end
   end
`else
   assign stall = 1'b0;
`endif

   assign cpu_access = cpu_req && !stall;
   assign scan_grant = (state_reg == SCAN_ISSUE) && !cpu_access;

   always_comb begin
      mem_addr = '0;
      mem_we   = 1'b0;
      if (cpu_access) begin
         mem_addr = cpu_addr;
         mem_we   = cpu_we;
      end else if (state_reg == SCAN_ISSUE) begin
         mem_addr = BASE_A + ADDR_W'(idx_reg);
      end
   end

   assign mem_wdata = cpu_wdata;
   assign cpu_rdata = mem_rdata;
   assign cpu_stall = stall;

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      case (state_reg)
         SCAN_IDLE: begin
            if (tick) begin
               state_next = SCAN_ISSUE;
               idx_next   = '0;
            end
         end
         SCAN_ISSUE: begin
            if (scan_grant) begin
               state_next = SCAN_CAPTURE;
            end
         end
         SCAN_CAPTURE: begin
            if (idx_reg == IDX_LAST) begin
               state_next = SCAN_DONE;
            end else begin
               idx_next   = idx_reg + IDX_W'(1);
               state_next = SCAN_ISSUE;
            end
         end
         default: begin
            state_next = SCAN_IDLE;
         end
      endcase
   end

   always_ff @(posedge clkX4) begin
      if (rst) begin
         state_reg      <= SCAN_IDLE;
         idx_reg        <= '0;
         disp_valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         if (state_reg == SCAN_DONE) begin
            disp_valid_reg <= 1'b1;
         end
      end
   end

   assign disp_valid = disp_valid_reg;
   assign frame_done = (state_reg == SCAN_DONE);

   // Offset compare avoids overflow when the window ends at the top of memory.
   assign win_offset = cpu_addr - BASE_A;
   assign in_window  = (cpu_addr >= BASE_A) && (win_offset < WORDS_A);
   assign snoop_en   = cpu_access && cpu_we && in_window;

   dmem_scan_arbiter_shadow #(
      .DATA_W (DATA_W),
      .WORDS  (DISP_WORDS),
      .IDX_W  (IDX_W)
   ) u_shadow (
      .clk        (clkX4),
      .srst       (rst),
      .cap_en     (state_reg == SCAN_CAPTURE),
      .cap_idx    (idx_reg),
      .cap_data   (mem_rdata),
      .snoop_en   (snoop_en),
      .snoop_idx  (win_offset[IDX_W-1:0]),
      .snoop_data (cpu_wdata),
      .rd_idx     (disp_sel),
      .rd_data    (disp_word)
   );

endmodule

// File: tb/tb_dmem_scan_arbiter.sv
// Randomized scoreboard bench for dmem_scan_arbiter; honours DMEM_SCAN_STARVE_STALL_EN.
module tb_dmem_scan_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int BASE   = 4096;
   localparam int WORDS  = 8;
   localparam int REF    = 128;
   localparam int MAXW   = 15;
`ifdef DMEM_SCAN_STARVE_STALL_EN
   localparam bit FEAT = 1'b1;
`else
   localparam bit FEAT = 1'b0;
`endif

   logic              clkX4 = 1'b0;
   logic              rst = 1'b0;
   logic              cpu_req = 1'b0;
   logic              cpu_we = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [2:0]        disp_sel = '0;
   logic [DATA_W-1:0] disp_word;
   logic              disp_valid;
   logic              frame_done;

   dmem_scan_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DISP_BASE(BASE), .DISP_WORDS(WORDS),
      .REFRESH_CYCLES(REF), .MAX_WAIT(MAXW)
   ) dut (
      .clkX4(clkX4), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .disp_sel(disp_sel),
      .disp_word(disp_word), .disp_valid(disp_valid), .frame_done(frame_done)
   );

   always #5 clkX4 = ~clkX4;

   typedef struct {
      bit          chk;
      logic [15:0] addr;
      bit          we;
      logic [31:0] wdata;
      bit          stall;
      bit          fd;
      bit          dv;
      logic [2:0]  sel;
      logic [31:0] dw;
      bit          rdv;
      logic [31:0] rd;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Environment memory (driven by the DUT port) and the model's own copy.
   logic [31:0] env_mem [int];
   logic [31:0] ref_mem [int];

   function automatic logic [31:0] init_val(input int a);
      return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   function automatic logic [31:0] env_rd(input int a);
      return env_mem.exists(a) ? env_mem[a] : init_val(a);
   endfunction

   function automatic logic [31:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   always @(posedge clkX4) begin
      mem_rdata <= env_rd(int'(mem_addr));
      if (mem_we) env_mem[int'(mem_addr)] = mem_wdata;
   end

   // Behavioural model: sweep progress as phase (0 idle, 1 wants slot, 2 capture, 3 done).
   int          m_cnt = 0, m_phase = 0, m_k = 0, m_wait = 0;
   logic [31:0] m_shadow [WORDS];
   logic [31:0] m_cap = '0;
   bit          m_valid = 0, m_known = 0;
   bit          pend_rdv = 0;
   logic [31:0] pend_rd = '0;
   int          cyc = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   always @(negedge clkX4) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.chk) begin
            cmp("mem_addr", 32'(mem_addr), 32'(e.addr));
            cmp("mem_we", 32'(mem_we), 32'(e.we));
            if (e.we) cmp("mem_wdata", mem_wdata, e.wdata);
            cmp("cpu_stall", 32'(cpu_stall), 32'(e.stall));
            cmp("frame_done", 32'(frame_done), 32'(e.fd));
            cmp("disp_valid", 32'(disp_valid), 32'(e.dv));
            cmp($sformatf("disp_word[%0d]", e.sel), disp_word, e.dw);
            if (e.rdv) cmp("cpu_rdata", cpu_rdata, e.rd);
         end
      end
   end

   task automatic step(input bit r, input bit req, input bit we, input logic [15:0] a,
                       input logic [31:0] wd, input logic [2:0] sel);
      exp_t e;
      bit   stall, acc, grant, tick;
      int   ai;
      ai = int'(a);
      rst = r; cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd; disp_sel = sel;
      stall = FEAT && (m_phase == 1) && req && (m_wait == MAXW);
      acc   = req && !stall;
      grant = (m_phase == 1) && !acc;
      e.chk = m_known;
      if (acc) begin
         e.addr = a; e.we = we;
      end else if (m_phase == 1) begin
         e.addr = 16'(BASE + m_k); e.we = 0;
      end else begin
         e.addr = '0; e.we = 0;
      end
      e.wdata = wd; e.stall = stall; e.fd = (m_phase == 3); e.dv = m_valid;
      e.sel = sel; e.dw = m_shadow[sel]; e.rdv = pend_rdv; e.rd = pend_rd;
      exp_q.push_back(e);
      pend_rdv = acc && !we;
      pend_rd  = ref_rd(ai);
      @(posedge clkX4);
      cyc++;
      if (r) begin
         m_cnt = 0; m_phase = 0; m_k = 0; m_wait = 0; m_valid = 0; m_known = 1;
         for (int i = 0; i < WORDS; i++) m_shadow[i] = '0;
      end else begin
         tick  = (m_cnt == REF - 1);
         m_cnt = tick ? 0 : m_cnt + 1;
         case (m_phase)
            0: if (tick) begin m_phase = 1; m_k = 0; end
            1: if (grant) begin
                  m_cap = ref_rd(BASE + m_k); m_phase = 2; m_wait = 0;
               end else m_wait++;
            2: begin
                  m_shadow[m_k] = m_cap;
                  if (m_k == WORDS - 1) m_phase = 3;
                  else begin m_k++; m_phase = 1; end
               end
            default: begin m_valid = 1; m_phase = 0; end
         endcase
         if (acc && we && ai >= BASE && ai < BASE + WORDS) m_shadow[ai - BASE] = wd;
      end
      if (acc && we) ref_mem[ai] = wd;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 3'(cyc));
   endtask

   task automatic wait_model(input int ph, input int k, input int bound);
      int n = 0;
      while (!(m_phase == ph && (k < 0 || m_k == k)) && n < bound) begin
         step(0, 0, 0, '0, '0, 3'(cyc));
         n++;
      end
      if (n >= bound) begin
         checks++; failures++;
         $display("FAIL wait_phase%0d_k%0d actual=timeout required=reached", ph, k);
      end
   endtask

   function automatic logic [15:0] pick_addr();
      int s = $urandom_range(0, 9);
      if (s < 6) return 16'(BASE + $urandom_range(0, WORDS - 1));
      if (s < 8) return 16'(BASE - 6 + $urandom_range(0, 20));
      return 16'($urandom);
   endfunction

   task automatic rand_run(input int n, input int rst_odds);
      int dens = 50;
      for (int i = 0; i < n; i++) begin
         if (i % 50 == 0) dens = $urandom_range(0, 100);
         step((rst_odds > 0) && ($urandom_range(1, rst_odds) == 1),
              $urandom_range(1, 100) <= dens, $urandom_range(0, 1) == 1,
              pick_addr(), $urandom, 3'($urandom));
      end
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++) begin
         env_mem[BASE + i] = 32'h11 * (i + 1);
         ref_mem[BASE + i] = 32'h11 * (i + 1);
         m_shadow[i] = '0;
      end
      @(posedge clkX4); #1;
      for (int i = 0; i < 3; i++) step(1, 0, 0, '0, '0, '0);
      idle(300);
      rand_run(600, 0);
      // Sustained CPU traffic while the scanner waits for a slot.
      wait_model(1, -1, 3 * REF);
      for (int i = 0; i < 40; i++) step(0, 1, 0, 16'(200 + i), '0, 3'(i));
      idle(60);
      // Snoop colliding with capture of the same entry.
      wait_model(2, 2, 3 * REF);
      step(0, 1, 1, 16'(BASE + 2), 32'hDEADBEEF, 3'd2);
      for (int i = 0; i < 20; i++) step(0, 0, 0, '0, '0, 3'd2);
      // Out-of-window write and in-window read mid-sweep.
      wait_model(1, -1, 3 * REF);
      step(0, 1, 1, 16'(BASE + WORDS), 32'hCAFEF00D, 3'd0);
      step(0, 1, 0, 16'(BASE + 4), '0, 3'd4);
      idle(30);
      // Reset in the middle of a sweep.
      wait_model(2, 5, 3 * REF);
      step(1, 0, 0, '0, '0, 3'd5);
      idle(20);
      rand_run(1500, 400);
      idle(2);
      @(negedge clkX4); #1;
      cmp("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_scan_arbiter.md
Name: dmem_scan_arbiter

Overview:
- Shares the single data-memory port between the CPU load/store path and a display scanner.
- The scanner periodically copies the result window (DISP_WORDS words starting at word DISP_BASE) into a shadow buffer, which the OLED driver reads.
- The CPU always has priority. The scanner uses only idle memory cycles.
- Sits between the cpu and dmem instances inside Main.

Parameters:
- ADDR_W, 16, word-address width of the dmem port.
- DATA_W, 32, data width.
- DISP_BASE, 4096, first word address of the display window.
- DISP_WORDS, 8, number of words in the window (power of 2, at most 16).
- REFRESH_CYCLES, 1024, clkX4 cycles from one sweep start to the next.
- MAX_WAIT, 15, starvation limit in cycles (used only with the optional feature).

Ports:
- clkX4  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- cpu_req  in  1  CPU memory access this cycle.
- cpu_we  in  1  CPU write enable (qualified by cpu_req).
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data, pass-through of mem_rdata.
- cpu_stall  out  1  one-cycle CPU hold (optional feature only; otherwise tied 0).
- mem_addr  out  ADDR_W  dmem address.
- mem_we  out  1  dmem write enable.
- mem_wdata  out  DATA_W  dmem write data.
- mem_rdata  in  DATA_W  dmem read data, valid 1 cycle after the address is presented.
- disp_sel  in  $clog2(DISP_WORDS)  shadow-buffer read index.
- disp_word  out  DATA_W  shadow[disp_sel], combinational.
- disp_valid  out  1  set after the first complete sweep; sticky.
- frame_done  out  1  one-cycle pulse when a sweep completes.

Behaviour:
- Reset values: all shadow entries 0, disp_valid 0, frame_done 0, cpu_stall 0, state IDLE, refresh counter 0, scan index 0. Reset asserted in any state, including mid-sweep, aborts the sweep immediately.
- Port mux (combinational):
  - cpu_req=1: mem_addr/mem_we/mem_wdata = CPU inputs.
  - Otherwise, in state ISSUE: mem_addr = DISP_BASE + idx, mem_we = 0.
  - Otherwise: mem_we = 0, mem_addr = 0.
  - The scanner never drives mem_we=1.
- Refresh counter: free-running. It wraps at REFRESH_CYCLES-1 and asserts tick on the wrap.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
  - IDLE: on tick, go to ISSUE with idx=0. A tick arriving outside IDLE is dropped, not queued.
  - ISSUE: if cpu_req=0, the scanner owns the port this cycle; go to CAPTURE. If cpu_req=1, stay in ISSUE (lost slot).
  - CAPTURE: shadow[idx] <= mem_rdata. If idx=DISP_WORDS-1, go to DONE; else idx+1 and go to ISSUE. CAPTURE never needs the port, so a CPU access in this cycle is unaffected.
  - DONE: frame_done=1 for exactly this cycle, disp_valid <= 1, go to IDLE.
- Minimum sweep time: 2*DISP_WORDS+1 cycles.
- Write snoop: a CPU write (cpu_req & cpu_we) with DISP_BASE <= cpu_addr < DISP_BASE+DISP_WORDS updates shadow[cpu_addr-DISP_BASE] in the same clock edge, in any state.
- Snoop vs. capture on the same entry in the same cycle: the snoop wins. The captured data is stale because the write occurred after the scanner's read.
- Address arithmetic: DISP_BASE+idx is computed at ADDR_W bits with no wrap. DISP_BASE+DISP_WORDS must be at most 2^ADDR_W; an elaboration-time check enforces this.
- cpu_rdata = mem_rdata unconditionally. The CPU ignores it when it issued no read.

Optional Feature:
- Macro: DMEM_SCAN_STARVE_STALL_EN.
- With the macro defined:
  - A wait counter increments each cycle the FSM sits in ISSUE with cpu_req=1, and clears on leaving ISSUE.
  - When the counter reaches MAX_WAIT, cpu_stall=1 for one cycle and the scanner takes the port regardless of cpu_req.
  - The CPU must hold its request and retry the next cycle.
  - No snoop occurs in a stalled cycle, since the CPU access is not performed.
- Without the macro: cpu_stall is constant 0, the scanner can starve indefinitely, and no counter exists.

Decomposition:
- Shared package (Types): DispIndexPath, DISP_BASE_ADDR, DISP_WORD_NUM, and the scan-state enum ScanState.
- One sub-module: dmem_scan_shadow. It holds the DISP_WORDS x DATA_W register file with two write sources (snoop over capture) and a combinational read port.

Test Plan:
- Idle CPU, preload mem[4096..4103] = 0x11..0x88: first sweep starts at cycle 1023, frame_done pulses 17 cycles later, disp_word(sel=3)=0x44, disp_valid=1.
- cpu_req held high for 40 cycles during ISSUE (feature off): no progress, cpu_stall stays 0, the sweep completes after cpu_req drops.
- Feature on, cpu_req held high: after 15 ISSUE cycles cpu_stall pulses once, mem_addr=DISP_BASE+idx that cycle, and the sweep advances.
- CPU writes 0xDEADBEEF to 4098 in the same cycle the scanner captures idx 2: shadow[2]=0xDEADBEEF.
- CPU write to 4104 (outside window) and read of 4100 mid-sweep: shadow unchanged, cpu_rdata equals mem[4100] one cycle later.
- rst asserted while in CAPTURE at idx 5: next cycle IDLE, all shadow entries 0, disp_valid=0, no frame_done pulse.
